// File: rtl/scratchpad_responder.sv
// scratchpad_responder
//   Memory-side responder for the cpu_to_l1 request/response protocol. It
//   serves fetches, loads and stores directly from an internal scratchpad of
//   64-bit words. There is no cache in front of it. Each access is held off
//   for a programmable number of wait states before the response appears.
//
// Parameters
//   DEPTH     number of 64-bit words (power of two, >= 2)
//   BASE_ADDR byte address of word 0 (aligned to DEPTH*8)
//   LATENCY   ready-low cycles per access (1..15)
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   cpu_to_l1__valid     request strobe, accepted only while ready=1
//   cpu_to_l1__ready     1 = idle, or response valid
//   cpu_to_l1__we        1 = store, 0 = load/fetch
//   cpu_to_l1__addr      byte address
//   cpu_to_l1__wr_data   store data, right-justified
//   cpu_to_l1__rd_data   load result, sign/zero extended to 64 bits
//   cpu_to_l1__dtype     access size/sign (0=D, 1/2=W s/u, 3/4=H s/u, 5/6=B s/u, 7=bad)
//   err                  response error flag, valid whenever ready=1
module scratchpad_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [63:0] BASE_ADDR = 64'h10000,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_to_l1__valid,
  output logic        cpu_to_l1__ready,
  input  logic        cpu_to_l1__we,
  input  logic [63:0] cpu_to_l1__addr,
  input  logic [63:0] cpu_to_l1__wr_data,
  output logic [63:0] cpu_to_l1__rd_data,
  input  logic [2:0]  cpu_to_l1__dtype,
  output logic        err
);

  localparam int          IDX_W = $clog2(DEPTH);
  localparam logic [63:0] SPAN  = 64'(DEPTH) << 3;
  localparam logic [3:0]  LAT   = 4'(LATENCY);

  // DONE is not a separate state: it is IDLE with the response registers
  // already loaded, so a new request can be taken in the first DONE cycle.
  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        accept;
  logic        do_access;

  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [2:0]  req_dtype;

  logic [63:0] rd_data_q;
  logic        err_q;

  logic [63:0] mem [DEPTH];

  logic [63:0]      offset;
  logic [IDX_W-1:0] idx;
  logic [2:0]       lane;
  logic [7:0]       size_mask;
  logic [7:0]       byte_en;
  logic [63:0]      bit_mask;
  logic             misaligned;
  logic             acc_err;
  logic [63:0]      old_word;
  logic [63:0]      shifted;
  logic [63:0]      load_val;
  logic [63:0]      merged;

  // Next-state logic. The wait counter is loaded with LATENCY on acceptance.
  // The access is performed on the BUSY cycle where the counter reads 1, so
  // ready stays low for exactly LATENCY cycles.
  always_comb begin
    state_next       = state;
    cnt_next         = cnt;
    accept           = 1'b0;
    do_access        = 1'b0;
    cpu_to_l1__ready = 1'b0;
    case (state)
      IDLE: begin
        cpu_to_l1__ready = 1'b1;
        if (cpu_to_l1__valid) begin
          accept     = 1'b1;
          state_next = BUSY;
          cnt_next   = LAT;
        end
      end
      BUSY: begin
        if (cnt == 4'd1) begin
          do_access  = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and wait counter. Reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Request capture. The CPU may change its outputs once the request has
  // been accepted, so the fields are held here for the whole busy window.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_we    <= cpu_to_l1__we;
      req_addr  <= cpu_to_l1__addr;
      req_wdata <= cpu_to_l1__wr_data;
      req_dtype <= cpu_to_l1__dtype;
    end
  end

  // Address decode, the error checks, load extraction and store merge.
  // An out-of-range address still produces an index inside the array.
  // The access that uses it is flagged as an error and has no effect.
  always_comb begin
    offset     = req_addr - BASE_ADDR;
    idx        = offset[3 +: IDX_W];
    lane       = offset[2:0];
    size_mask  = 8'h00;
    misaligned = 1'b0;
    case (req_dtype)
      3'd0:       begin size_mask = 8'hFF; misaligned = (req_addr[2:0] != 3'd0); end
      3'd1, 3'd2: begin size_mask = 8'h0F; misaligned = (req_addr[1:0] != 2'd0); end
      3'd3, 3'd4: begin size_mask = 8'h03; misaligned = req_addr[0]; end
      3'd5, 3'd6: begin size_mask = 8'h01; misaligned = 1'b0; end
      default:    begin size_mask = 8'h00; misaligned = 1'b0; end
    endcase
    acc_err = (req_addr < BASE_ADDR) || (offset >= SPAN) || misaligned ||
              (req_dtype == 3'd7);

    old_word = mem[idx];
    shifted  = old_word >> {lane, 3'b000};
    case (req_dtype)
      3'd1:    load_val = {{32{shifted[31]}}, shifted[31:0]};
      3'd2:    load_val = {32'd0, shifted[31:0]};
      3'd3:    load_val = {{48{shifted[15]}}, shifted[15:0]};
      3'd4:    load_val = {48'd0, shifted[15:0]};
      3'd5:    load_val = {{56{shifted[7]}}, shifted[7:0]};
      3'd6:    load_val = {56'd0, shifted[7:0]};
      default: load_val = shifted;
    endcase

    // The byte enables are the size mask moved up to the addressed lane.
    // Only those lanes take the low bytes of wr_data.
    byte_en  = size_mask << lane;
    bit_mask = 64'd0;
    for (int b = 0; b < 8; b++) begin
      bit_mask[b*8 +: 8] = {8{byte_en[b]}};
    end
    merged = (old_word & ~bit_mask) | ((req_wdata << {lane, 3'b000}) & bit_mask);
  end

  // Store commit. The contents are not reset. The rst gate makes a reset on
  // the commit cycle drop the store, the same as a reset earlier in BUSY.
  always_ff @(posedge clk) begin
    if (!rst && do_access && req_we && !acc_err) begin
      mem[idx] <= merged;
    end
  end

  // Response registers. They are loaded on the access cycle and then hold
  // through DONE/IDLE until the next access completes. Errors and stores
  // return zero data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= 64'd0;
      err_q     <= 1'b0;
    end else if (do_access) begin
      err_q     <= acc_err;
      rd_data_q <= (acc_err || req_we) ? 64'd0 : load_val;
    end
  end

  assign cpu_to_l1__rd_data = rd_data_q;
  assign err                = err_q;

endmodule

// File: tb/tb_scratchpad_responder.sv
// tb_scratchpad_responder
//   Self-checking bench for scratchpad_responder using the default geometry
//   (DEPTH=1024, BASE_ADDR=0x10000, LATENCY=2). A vector table drives plain
//   accesses. Short hand-written sequences cover reset, a valid held high
//   through BUSY, and a reset during a store.
module tb_scratchpad_responder;

  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned LATENCY = 2;
  localparam logic [63:0] BASE    = 64'h10000;
  localparam int          NVEC    = 23;

  logic        clk;
  logic        rst;
  logic        valid;
  logic        ready;
  logic        we;
  logic [63:0] addr;
  logic [63:0] wr_data;
  logic [63:0] rd_data;
  logic [2:0]  dtype;
  logic        err;

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [2:0]  dtype;
    logic [63:0] exp_rd;
    logic        exp_err;
  } req_t;

  typedef struct packed {
    logic [63:0] rd;
    logic        err;
  } resp_t;

  req_t  vecs [NVEC];
  resp_t exp_q [$];
  int    check_count = 0;
  int    pass_count  = 0;

  scratchpad_responder #(
    .DEPTH(DEPTH),
    .BASE_ADDR(BASE),
    .LATENCY(LATENCY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cpu_to_l1__valid(valid),
    .cpu_to_l1__ready(ready),
    .cpu_to_l1__we(we),
    .cpu_to_l1__addr(addr),
    .cpu_to_l1__wr_data(wr_data),
    .cpu_to_l1__rd_data(rd_data),
    .cpu_to_l1__dtype(dtype),
    .err(err)
  );

  // Free-running clock with a 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Counts the ready-low cycles after an acceptance. The count is bounded so
  // a stuck DUT still reaches the summary. The response is then checked
  // against the oldest expected entry in the scoreboard.
  task automatic check_output(input string tag);
    int    busy;
    resp_t exp;
    busy = 0;
    @(negedge clk);
    while (ready !== 1'b1 && busy < 50) begin
      busy++;
      @(negedge clk);
    end
    check_val({tag, "_latency"}, 64'(busy), 64'(LATENCY));
    exp = exp_q.pop_front();
    check_val({tag, "_rd"}, rd_data, exp.rd);
    check_val({tag, "_err"}, 64'(err), 64'(exp.err));
  endtask

  // Presents one request for a single cycle while the DUT is idle. The
  // expected response goes into the scoreboard, then the response is awaited.
  task automatic apply_stimulus(input req_t r, input string tag);
    @(negedge clk);
    valid   = 1'b1;
    we      = r.we;
    addr    = r.addr;
    wr_data = r.wdata;
    dtype   = r.dtype;
    exp_q.push_back('{r.exp_rd, r.exp_err});
    @(posedge clk);
    #1;
    valid = 1'b0;
    check_output(tag);
  endtask

  // Main test sequence.
  initial begin
    //          we    addr          wdata                   dtype exp_rd                  exp_err
    vecs[0]  = '{1'b1, 64'h10000, 64'hFFFF_FFFF_8000_0013, 3'd0, 64'h0,                  1'b0};
    vecs[1]  = '{1'b0, 64'h10000, 64'h0,                   3'd1, 64'hFFFF_FFFF_8000_0013, 1'b0};
    vecs[2]  = '{1'b0, 64'h10000, 64'h0,                   3'd2, 64'h0000_0000_8000_0013, 1'b0};
    vecs[3]  = '{1'b0, 64'h10004, 64'h0,                   3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[4]  = '{1'b0, 64'h10002, 64'h0,                   3'd3, 64'hFFFF_FFFF_FFFF_8000, 1'b0};
    vecs[5]  = '{1'b0, 64'h10000, 64'h0,                   3'd4, 64'h0000_0000_0000_0013, 1'b0};
    vecs[6]  = '{1'b1, 64'h10000, 64'h1122_3344_5566_7788, 3'd0, 64'h0,                  1'b0};
    vecs[7]  = '{1'b1, 64'h10005, 64'h5A5A_5A5A_5A5A_5AAB, 3'd5, 64'h0,                  1'b0};
    vecs[8]  = '{1'b0, 64'h10005, 64'h0,                   3'd5, 64'hFFFF_FFFF_FFFF_FFAB, 1'b0};
    vecs[9]  = '{1'b0, 64'h10005, 64'h0,                   3'd6, 64'h0000_0000_0000_00AB, 1'b0};
    vecs[10] = '{1'b0, 64'h10000, 64'h0,                   3'd0, 64'h1122_AB44_5566_7788, 1'b0};
    vecs[11] = '{1'b1, 64'h10003, 64'hFFFF,                3'd3, 64'h0,                  1'b1};
    vecs[12] = '{1'b0, 64'h10000, 64'h0,                   3'd0, 64'h1122_AB44_5566_7788, 1'b0};
    vecs[13] = '{1'b0, 64'h12000, 64'h0,                   3'd0, 64'h0,                  1'b1};
    vecs[14] = '{1'b0, 64'h0FFF8, 64'h0,                   3'd0, 64'h0,                  1'b1};
    vecs[15] = '{1'b0, 64'h10000, 64'h0,                   3'd7, 64'h0,                  1'b1};
    vecs[16] = '{1'b1, 64'h10004, 64'h1111_2222_CAFE_BABE, 3'd1, 64'h0,                  1'b0};
    vecs[17] = '{1'b0, 64'h10000, 64'h0,                   3'd0, 64'hCAFE_BABE_5566_7788, 1'b0};
    vecs[18] = '{1'b1, 64'h11FF8, 64'h0123_4567_89AB_CDEF, 3'd0, 64'h0,                  1'b0};
    vecs[19] = '{1'b0, 64'h11FFE, 64'h0,                   3'd3, 64'h0000_0000_0000_0123, 1'b0};
    vecs[20] = '{1'b0, 64'h10001, 64'h0,                   3'd0, 64'h0,                  1'b1};
    vecs[21] = '{1'b1, 64'h10008, 64'h0BAD_F00D_0000_1111, 3'd0, 64'h0,                  1'b0};
    vecs[22] = '{1'b0, 64'h11FFA, 64'h0,                   3'd3, 64'hFFFF_FFFF_FFFF_89AB, 1'b0};

    rst     = 1'b1;
    valid   = 1'b0;
    we      = 1'b0;
    addr    = 64'h0;
    wr_data = 64'h0;
    dtype   = 3'd0;

    // Power-on reset for two cycles, then the reset values.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("por_ready", 64'(ready), 64'd1);
    check_val("por_rd", rd_data, 64'd0);
    check_val("por_err", 64'(err), 64'd0);

    for (int i = 0; i < NVEC; i++) begin
      apply_stimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Valid held high through BUSY with a changing address. Only the first
    // request may be serviced. The 0x12000 address presented during BUSY
    // would give an error if it were taken. The next request is taken in
    // the first DONE cycle.
    @(negedge clk);
    valid = 1'b1;
    we    = 1'b0;
    addr  = 64'h10000;
    dtype = 3'd0;
    exp_q.push_back('{64'hCAFE_BABE_5566_7788, 1'b0});
    @(posedge clk);
    #1;
    addr = 64'h12000;
    check_output("spurious_first");
    addr = 64'h10008;
    exp_q.push_back('{64'h0BAD_F00D_0000_1111, 1'b0});
    @(posedge clk);
    #1;
    valid = 1'b0;
    check_output("spurious_second");

    // Reset on the first BUSY cycle of a doubleword store. The store must
    // be dropped and the responder must come back idle with a cleared
    // response.
    @(negedge clk);
    valid   = 1'b1;
    we      = 1'b1;
    addr    = 64'h10008;
    wr_data = 64'hDEAD_BEEF;
    dtype   = 3'd0;
    @(posedge clk);
    #1;
    valid = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    check_val("abort_busy_ready", 64'(ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("abort_ready", 64'(ready), 64'd1);
    check_val("abort_rd", rd_data, 64'd0);
    check_val("abort_err", 64'(err), 64'd0);
    apply_stimulus('{1'b0, 64'h10008, 64'h0, 3'd0, 64'h0BAD_F00D_0000_1111, 1'b0}, "abort_load");

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
